// File: rtl/spy_pkg.sv
// Shared types and helpers for the spy buffer playback block.
package spy_pkg;

    // Playback sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StRead,
        StDrain,
        StDone
    } spy_state_e;

    // Header bit positions, counted down from the MSB of the data word.
    localparam int unsigned HdrMarkerFromMsb  = 1;
    localparam int unsigned HdrWrappedFromMsb = 2;

    // Header word: marker bit at the MSB, wrapped flag just below it,
    // word count in the low bits, everything else zero.
    function automatic logic [63:0] spy_header_word(input int unsigned datawidth,
                                                    input logic        wrapped,
                                                    input logic [31:0] count);
        logic [63:0] word;
        word = {32'b0, count};
        word[6'(datawidth - HdrMarkerFromMsb)]  = 1'b1;
        word[6'(datawidth - HdrWrappedFromMsb)] = wrapped;
        return word;
    endfunction

endpackage

// File: rtl/spy_skid_fifo.sv
// Two-entry valid/ready FIFO that decouples memory read latency from the consumer.
module spy_skid_fifo #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [DATAWIDTH-1:0] pop_data,
    output logic                 not_empty,
    output logic [1:0]           count
);

    logic [DATAWIDTH-1:0] entries_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 pop_fire;
    logic                 push_fire;

    assign pop_fire  = pop && (count_q != 2'd0);
    // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
    assign push_fire = push && ((count_q != 2'd2) || pop_fire);

    assign pop_data  = entries_q[rd_ptr_q];
    assign not_empty = (count_q != 2'd0);
    assign count     = count_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries_q <= '{default: '0};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_fire) begin
                entries_q[wr_ptr_q] <= push_data;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_fire} - {1'b0, pop_fire};
        end
    end

endmodule

// File: rtl/spy_playback.sv
// Spy buffer playback: freezes the circular memory, snapshots the write pointer
// and streams the stored words oldest-to-newest over valid/ready with a last marker.
// Optional build macro SPY_PLAYBACK_HEADER_EN prepends a header word to every dump.
module spy_playback
    import spy_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 playback_req,
    input  logic                 mem_write_enable,
    input  logic [WIDTH-1:0]     mem_write_pointer,
    input  logic                 mem_looped,
    output logic                 freeze,
    output logic [WIDTH-1:0]     mem_read_addr,
    output logic                 mem_read_enable,
    input  logic [DATAWIDTH-1:0] mem_read_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [WIDTH-1:0] PtrLast = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   CntSize = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   CntOne  = {{WIDTH{1'b0}}, 1'b1};

    spy_state_e state_q, state_d;

    logic                 wrapped_q;
    logic [WIDTH-1:0]     start_q;
    logic [WIDTH:0]       count_q;
    logic [WIDTH:0]       issued_q;
    logic                 inflight_q;
    logic                 inflight_last_q;

    logic [WIDTH-1:0]     snap_start;
    logic [WIDTH:0]       snap_count;
    logic                 last_issue;
    logic                 issue;
    logic [1:0]           occ;

    logic                 skid_push;
    logic [DATAWIDTH:0]   skid_din;
    logic [DATAWIDTH:0]   skid_dout;
    logic                 skid_not_empty;
    logic [1:0]           skid_count;
    logic                 pop_fire;
    logic                 hdr_push;
    logic [DATAWIDTH-1:0] hdr_word;

    // The looped flag is redundant with the pointer compare used for wrap tracking.
    logic                 unused_looped;
    assign unused_looped = mem_looped;

    assign snap_start = wrapped_q ? mem_write_pointer : '0;
    assign snap_count = wrapped_q ? CntSize : {1'b0, mem_write_pointer};

    assign last_issue = (issued_q == (count_q - CntOne));
    assign pop_fire   = skid_not_empty && out_ready;
    // Occupancy as it will stand next cycle, so a word popped now frees room for a
    // new read and a held-high out_ready sustains one word per cycle.
    assign occ        = skid_count - {1'b0, pop_fire} + {1'b0, inflight_q};
    assign issue      = (state_q == StRead) && (occ < 2'd2);

`ifdef SPY_PLAYBACK_HEADER_EN
    assign hdr_push = (state_q == StSnap);
    assign hdr_word = DATAWIDTH'(spy_header_word(DATAWIDTH, wrapped_q, 32'(snap_count)));
`else
    assign hdr_push = 1'b0;
    assign hdr_word = '0;
`endif

    // Header and memory data never collide: the header is pushed in SNAP, reads return later.
    assign skid_push = inflight_q || hdr_push;
    assign skid_din  = inflight_q ? {inflight_last_q, mem_read_data}
                                  : {(snap_count == '0), hdr_word};

    spy_skid_fifo #(
        .DATAWIDTH (DATAWIDTH + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (skid_push),
        .push_data (skid_din),
        .pop       (out_ready),
        .pop_data  (skid_dout),
        .not_empty (skid_not_empty),
        .count     (skid_count)
    );

    assign out_valid = skid_not_empty;
    assign out_last  = skid_dout[DATAWIDTH] && skid_not_empty;
    assign out_data  = skid_not_empty ? skid_dout[DATAWIDTH-1:0] : '0;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (playback_req) state_d = StSnap;
            // An empty dump still passes through DRAIN so any header word is flushed.
            StSnap:  state_d = (snap_count == '0) ? StDrain : StRead;
            StRead:  if (issue && last_issue) state_d = StDrain;
            StDrain: if (!inflight_q && !skid_not_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        freeze          = (state_q != StIdle);
        busy            = (state_q != StIdle);
        mem_read_enable = issue;
        mem_read_addr   = issue ? (start_q + issued_q[WIDTH-1:0]) : '0;
    end

    // Wrap tracking, snapshot and read bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrapped_q       <= 1'b0;
            start_q         <= '0;
            count_q         <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (state_q == StDone) begin
                wrapped_q <= 1'b0;
            end else if (mem_write_enable && (mem_write_pointer == PtrLast)) begin
                wrapped_q <= 1'b1;
            end
            if (state_q == StSnap) begin
                start_q  <= snap_start;
                count_q  <= snap_count;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + CntOne;
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
        end
    end

endmodule
